// File: rtl/apb_noc_requester_ni.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_noc_requester_ni
// Purpose  : Network-interface requester bridging a local APB requester to the
//            NI port of its mesh router. One APB transfer becomes one request
//            packet. The NI then waits for the matching response packet and
//            completes the APB ACCESS phase. A timeout guards against lost
//            responses. Only one transfer is outstanding at a time.
// Ports    : i_clk, i_arst_n            clock, async active-low reset
//            i_psel/i_penable/i_pwrite   APB control
//            i_paddr/i_pwdata            APB address / write data
//            o_pready/o_prdata/o_pslverr APB completion
//            o_txPacket/o_txValid/i_txReady  request stream to router
//            i_rxPacket/i_rxValid/o_rxReady  packet stream from router
//            o_dropPulse                 accepted rx packet was discarded
// Revision : 1.0  initial release
// ============================================================================
module apb_noc_requester_ni #(
  parameter int GRID_WIDTH       = 4,
  parameter int NI_ROW           = 0,
  parameter int NI_COL           = 0,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int TIMEOUT_CYCLES   = 1023,
  // Packet width the NoC fabric is built for; must agree with the local width.
  parameter int NOC_PACKET_WIDTH = 75,
  localparam int COORD_W          = $clog2(GRID_WIDTH),
  localparam int APB_PACKET_WIDTH = 4*COORD_W + 3 + ADDR_W + DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [ADDR_W-1:0]           i_paddr,
  input  logic [DATA_W-1:0]           i_pwdata,
  output logic                        o_pready,
  output logic [DATA_W-1:0]           o_prdata,
  output logic                        o_pslverr,
  output logic [APB_PACKET_WIDTH-1:0] o_txPacket,
  output logic                        o_txValid,
  input  logic                        i_txReady,
  input  logic [APB_PACKET_WIDTH-1:0] i_rxPacket,
  input  logic                        i_rxValid,
  output logic                        o_rxReady,
  output logic                        o_dropPulse
);

  // Packet field offsets (LSB first: dst, src, isRsp, write, err, addr, data)
  localparam int c_IS_RSP   = 4*COORD_W;
  localparam int c_WRITE    = 4*COORD_W + 1;
  localparam int c_ERR      = 4*COORD_W + 2;
  localparam int c_ADDR_LSB = 4*COORD_W + 3;
  localparam int c_DATA_LSB = c_ADDR_LSB + ADDR_W;

  localparam logic [2*COORD_W-1:0] c_SELF = {NI_ROW[COORD_W-1:0], NI_COL[COORD_W-1:0]};

  // Timeout counter; a zero limit disables the timeout entirely.
  localparam bit   c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int   c_CNT_W      = c_TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int   c_CNT_LAST_I = c_TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_LAST_I[c_CNT_W-1:0];

  generate
    if (APB_PACKET_WIDTH != NOC_PACKET_WIDTH) begin : g_widthCheck
      $error("apb_noc_requester_ni: packet width does not match NoC packet width");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;

  // Request fields are read back from the held tx packet, which stays
  // unchanged until the next transfer is captured.
  logic [2*COORD_W-1:0]        w_reqDst;
  logic [ADDR_W-1:0]           w_reqAddr;
  logic                        w_reqWrite;
  logic [2*COORD_W-1:0]        w_rxDst;
  logic [2*COORD_W-1:0]        w_rxSrc;
  logic [ADDR_W-1:0]           w_rxAddr;
  logic [DATA_W-1:0]           w_rxData;
  logic                        w_rxAccept;
  logic                        w_match;
  logic                        w_timeout;
  logic [APB_PACKET_WIDTH-1:0] w_reqPacket;
  logic                        w_unusedRxWrite;

  assign w_reqDst   = o_txPacket[2*COORD_W-1:0];
  assign w_reqAddr  = o_txPacket[c_ADDR_LSB +: ADDR_W];
  assign w_reqWrite = o_txPacket[c_WRITE];

  assign w_rxDst  = i_rxPacket[2*COORD_W-1:0];
  assign w_rxSrc  = i_rxPacket[4*COORD_W-1:2*COORD_W];
  assign w_rxAddr = i_rxPacket[c_ADDR_LSB +: ADDR_W];
  assign w_rxData = i_rxPacket[c_DATA_LSB +: DATA_W];
  // The response's write flag carries no information the NI needs.
  assign w_unusedRxWrite = i_rxPacket[c_WRITE];

  assign w_rxAccept = i_rxValid & o_rxReady;
  assign w_match    = w_rxAccept & (r_state == WAIT_RSP) & i_rxPacket[c_IS_RSP] &
                      (w_rxDst == c_SELF) & (w_rxSrc == w_reqDst) & (w_rxAddr == w_reqAddr);
  assign w_timeout  = c_TIMEOUT_EN & (r_cnt == c_CNT_LAST);

  // Destination comes from the top address bits; source is this tile.
  assign w_reqPacket = {i_pwdata, i_paddr, 1'b0, i_pwrite, 1'b0, c_SELF,
                        i_paddr[ADDR_W-1 -: 2*COORD_W]};

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      o_pready    <= 1'b0;
      o_prdata    <= '0;
      o_pslverr   <= 1'b0;
      o_txPacket  <= '0;
      o_txValid   <= 1'b0;
      o_rxReady   <= 1'b0;
      o_dropPulse <= 1'b0;
    end else begin
      // Any accepted packet that does not complete the transfer is dropped.
      o_dropPulse <= w_rxAccept & ~w_match;
      // rx is stalled only while in DONE; overridden on the entry into DONE.
      o_rxReady   <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_psel && i_penable) begin
            o_txPacket <= w_reqPacket;
            o_txValid  <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (i_txReady) begin
            o_txValid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (w_match) begin
            o_prdata  <= w_reqWrite ? '0 : w_rxData;
            o_pslverr <= i_rxPacket[c_ERR];
            o_pready  <= 1'b1;
            o_rxReady <= 1'b0;
            r_state   <= DONE;
          end else if (w_timeout) begin
            o_prdata  <= '0;
            o_pslverr <= 1'b1;
            o_pready  <= 1'b1;
            o_rxReady <= 1'b0;
            r_state   <= DONE;
          end else if (r_cnt != {c_CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        DONE: begin
          o_pready  <= 1'b0;
          o_prdata  <= '0;
          o_pslverr <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
